i2s_target_if: RTL and testbench

- I2S target (codec-side) engine. It receives SCLK/LRCLK from an external I2S controller, deserialises SDIN into per-channel samples, and serialises per-channel samples onto SDOUT.
- It is the far end of the existing codec interface. Uses: a synthesizable codec stand-in for FPGA loopback benches, and running the audio path as a clock slave.
- All logic runs on the fast system clock; I2S pins are oversampled.

---
 rtl/i2s_target_if.sv | 221 ++++++++++++++++++++++
 tb/tb_i2s_target_if.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_target_if.sv
// -----------------------------------------------------------------------------
// i2s_target_if
//
// I2S target (codec-side) engine.
// - Takes SCLK/LRCLK from an external I2S controller.
// - Deserialises SDIN into per-channel samples.
// - Serialises per-channel samples onto SDOUT.
// All logic runs on clk. The I2S pins are oversampled, so clk must be at
// least 8x the SCLK frequency.
//
// Framing is standard I2S (Philips) with a one-SCLK data delay after each
// LRCLK change:
// - The rising SCLK that first sees a new LRCLK level is called R0.
// - The bit sampled at R0 is still the LSB of the previous slot.
//
// Ports
//   clk, rst              system clock; synchronous active-high reset
//   i2s_sclk/lrclk/sdin   controller-driven I2S pins (asynchronous to clk)
//   i2s_sdout             serial data back to the controller
//   rx_data / rx_vld      last received sample; one-hot per-channel pulse
//   tx_din0 / tx_din1     samples to transmit on channel 0 / channel 1
//   tx_ack                per-channel pulse: that tx_din has been latched
//   err_clr / frame_err   clear / sticky short-slot flag
//   active                framing locked
//   loopback              (only with I2S_TGT_LOOPBACK_EN) echo RX samples
//
// Build option
//   Define I2S_TGT_LOOPBACK_EN to add the loopback input. While loopback is
//   high, each TX slot reloads the last sample received on the same channel
//   instead of tx_din0/tx_din1.
// -----------------------------------------------------------------------------
module i2s_target_if #(
  parameter int DATA_W      = 24,
  parameter int SLOT_W      = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i2s_sclk,
  input  logic              i2s_lrclk,
  input  logic              i2s_sdin,
  output logic              i2s_sdout,
  output logic [DATA_W-1:0] rx_data,
  output logic [1:0]        rx_vld,
  input  logic [DATA_W-1:0] tx_din0,
  input  logic [DATA_W-1:0] tx_din1,
  output logic [1:0]        tx_ack,
  input  logic              err_clr,
  output logic              frame_err,
  output logic              active
`ifdef I2S_TGT_LOOPBACK_EN
  ,
  input  logic              loopback
`endif
);

  localparam int CNT_W = $clog2(SLOT_W + 1);
  localparam int TXC_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(SLOT_W - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] CNT_DATA = CNT_W'(DATA_W);
  localparam logic [TXC_W-1:0] TX_DONE  = TXC_W'(DATA_W);

  typedef enum logic {SEEK, ACTIVE} state_t;

  // Pin synchronisers plus one history flop on SCLK.
  // These flops are pure pin delay and carry no state, so they are not reset.
  logic [SYNC_STAGES-1:0] sclk_sync_q;
  logic [SYNC_STAGES-1:0] lr_sync_q;
  logic [SYNC_STAGES-1:0] din_sync_q;
  logic                   sclk_hist_q;

  always_ff @(posedge clk) begin
    sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], i2s_sclk};
    lr_sync_q   <= {lr_sync_q[SYNC_STAGES-2:0], i2s_lrclk};
    din_sync_q  <= {din_sync_q[SYNC_STAGES-2:0], i2s_sdin};
    sclk_hist_q <= sclk_sync_q[SYNC_STAGES-1];
  end

  logic sclk_s, lr_s, din_s, rise, fall;
  assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
  assign lr_s   = lr_sync_q[SYNC_STAGES-1];
  assign din_s  = din_sync_q[SYNC_STAGES-1];
  assign rise   = sclk_s & ~sclk_hist_q;
  assign fall   = ~sclk_s & sclk_hist_q;

  // Framing / datapath state
  state_t             state_q;
  logic               active_q;
  logic               lr_prev_q;   // LRCLK level seen at the previous rising strobe
  logic               lr_seen_q;   // lr_prev_q holds a real sample
  logic               ch_q;        // channel of the slot being received
  logic [CNT_W-1:0]   bit_cnt_q;
  logic [CNT_W-1:0]   bit_cnt_d;
  logic [DATA_W-2:0]  rx_sr_q;     // the newest bit is appended on capture
  logic [DATA_W-1:0]  rx_word;
  logic [DATA_W-1:0]  rx_data_q;
  logic [1:0]         rx_vld_q;
  logic [DATA_W-1:0]  tx_sr_q;
  logic [TXC_W-1:0]   tx_cnt_q;    // bits already driven in this slot
  logic               sdout_q;
  logic [1:0]         tx_ack_q;
  logic               frame_err_q;
  logic [DATA_W-1:0]  tx_new;

  logic lr_chg, cap_bit, last_bit, short_slot;

  always_comb begin
    lr_chg     = lr_seen_q && (lr_s != lr_prev_q);
    cap_bit    = (bit_cnt_q < CNT_DATA);
    last_bit   = (bit_cnt_q == CNT_LAST);
    // The R0 bit still counts toward the closing slot. The slot is short if
    // even that bit leaves it below DATA_W bits.
    short_slot = (bit_cnt_q < CNT_LAST);
    rx_word    = {rx_sr_q, din_s};
    bit_cnt_d  = (bit_cnt_q == CNT_MAX) ? bit_cnt_q : bit_cnt_q + CNT_W'(1);
  end

`ifdef I2S_TGT_LOOPBACK_EN
  logic [DATA_W-1:0] lb0_q;
  logic [DATA_W-1:0] lb1_q;
  assign tx_new = loopback ? (lr_s ? lb1_q : lb0_q)
                           : (lr_s ? tx_din1 : tx_din0);
`else
  assign tx_new = lr_s ? tx_din1 : tx_din0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= SEEK;
      active_q    <= 1'b0;
      lr_prev_q   <= 1'b0;
      lr_seen_q   <= 1'b0;
      ch_q        <= 1'b0;
      bit_cnt_q   <= '0;
      rx_sr_q     <= '0;
      rx_data_q   <= '0;
      rx_vld_q    <= '0;
      tx_sr_q     <= '0;
      tx_cnt_q    <= TX_DONE;
      sdout_q     <= 1'b0;
      tx_ack_q    <= '0;
      frame_err_q <= 1'b0;
`ifdef I2S_TGT_LOOPBACK_EN
      lb0_q       <= '0;
      lb1_q       <= '0;
`endif
    end else begin
      rx_vld_q <= '0;
      tx_ack_q <= '0;
      // A clear is overridden by a set further down in the same clk.
      if (err_clr) frame_err_q <= 1'b0;
      if (rise) begin
        lr_prev_q <= lr_s;
        lr_seen_q <= 1'b1;
      end

      case (state_q)
        SEEK: begin
          // The first LRCLK change opens the first complete slot.
          // No closing slot exists yet, so no error check is made here.
          if (rise && lr_chg) begin
            state_q      <= ACTIVE;
            active_q     <= 1'b1;
            ch_q         <= lr_s;
            bit_cnt_q    <= '0;
            tx_sr_q      <= tx_new;
            tx_cnt_q     <= '0;
            tx_ack_q[lr_s] <= 1'b1;
          end
        end

        ACTIVE: begin
          if (rise) begin
            if (cap_bit) rx_sr_q <= rx_word[DATA_W-2:0];
            if (last_bit) begin
              rx_data_q      <= rx_word;
              rx_vld_q[ch_q] <= 1'b1;
`ifdef I2S_TGT_LOOPBACK_EN
              if (ch_q) lb1_q <= rx_word;
              else      lb0_q <= rx_word;
`endif
            end
            if (lr_chg) begin
              if (short_slot) frame_err_q <= 1'b1;
              ch_q           <= lr_s;
              bit_cnt_q      <= '0;
              tx_sr_q        <= tx_new;
              tx_cnt_q       <= '0;
              tx_ack_q[lr_s] <= 1'b1;
            end else begin
              bit_cnt_q <= bit_cnt_d;
            end
          end

          // The first falling strobe after R0 drives the MSB. Once DATA_W
          // bits are out, the line idles low until the next reload.
          if (fall) begin
            if (tx_cnt_q != TX_DONE) begin
              sdout_q  <= tx_sr_q[DATA_W-1];
              tx_sr_q  <= {tx_sr_q[DATA_W-2:0], 1'b0};
              tx_cnt_q <= tx_cnt_q + TXC_W'(1);
            end else begin
              sdout_q  <= 1'b0;
            end
          end
        end

        default: state_q <= SEEK;
      endcase
    end
  end

  assign i2s_sdout = sdout_q;
  assign rx_data   = rx_data_q;
  assign rx_vld    = rx_vld_q;
  assign tx_ack    = tx_ack_q;
  assign frame_err = frame_err_q;
  assign active    = active_q;

endmodule

// File: tb/tb_i2s_target_if.sv
module tb_i2s_target_if;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i2s_sclk = 1'b1;
  logic        i2s_lrclk = 1'b0;
  logic        i2s_sdin = 1'b0;
  logic        i2s_sdout;
  logic [23:0] rx_data;
  logic [1:0]  rx_vld;
  logic [23:0] tx_din0 = 24'h800001;
  logic [23:0] tx_din1 = 24'h7FFFFE;
  logic [1:0]  tx_ack;
  logic        err_clr = 1'b0;
  logic        frame_err;
  logic        active;
`ifdef I2S_TGT_LOOPBACK_EN
  logic        loopback = 1'b0;
`endif

  i2s_target_if #(.DATA_W(24), .SLOT_W(32), .SYNC_STAGES(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .i2s_sclk  (i2s_sclk),
    .i2s_lrclk (i2s_lrclk),
    .i2s_sdin  (i2s_sdin),
    .i2s_sdout (i2s_sdout),
    .rx_data   (rx_data),
    .rx_vld    (rx_vld),
    .tx_din0   (tx_din0),
    .tx_din1   (tx_din1),
    .tx_ack    (tx_ack),
    .err_clr   (err_clr),
    .frame_err (frame_err),
    .active    (active)
`ifdef I2S_TGT_LOOPBACK_EN
    ,
    .loopback  (loopback)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Event recorder: tallies the output pulses seen on each clk.
  int          rxc0 = 0, rxc1 = 0, txa0 = 0, txa1 = 0;
  int          coin = 0, both_rx = 0, long_rx = 0, long_tx = 0;
  logic [23:0] last0 = '0, last1 = '0;
  logic [1:0]  rx_prev = '0, tx_prev = '0;

  always @(negedge clk) begin
    if (rx_vld[0]) begin rxc0 <= rxc0 + 1; last0 <= rx_data; end
    if (rx_vld[1]) begin rxc1 <= rxc1 + 1; last1 <= rx_data; end
    if (tx_ack[0]) txa0 <= txa0 + 1;
    if (tx_ack[1]) txa1 <= txa1 + 1;
    if (rx_vld == 2'b11) both_rx <= both_rx + 1;
    if (rx_vld != 2'b00 && tx_ack != 2'b00) coin <= coin + 1;
    if (rx_vld != 2'b00 && rx_prev != 2'b00) long_rx <= long_rx + 1;
    if (tx_ack != 2'b00 && tx_prev != 2'b00) long_tx <= long_tx + 1;
    rx_prev <= rx_vld;
    tx_prev <= tx_ack;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One SCLK period of 8 clk. Lrclk and sdin change with the falling edge.
  // Sdout is sampled just before the rising edge, as the controller would.
  task automatic sclk_cycle(input logic lr, input logic din, output logic dout);
    i2s_sclk  = 1'b0;
    i2s_lrclk = lr;
    i2s_sdin  = din;
    repeat (4) @(posedge clk);
    #1;
    dout     = i2s_sdout;
    i2s_sclk = 1'b1;
    repeat (4) @(posedge clk);
    #1;
  endtask

  // Controller-side slot model.
  // - The MSB goes out at the second falling edge of the slot.
  // - The first cycle of a slot carries the previous slot's last bit.
  // - done_cap gets the previous slot's sdout capture, MSB-aligned in 32 bits.
  logic        pend_bit = 1'b0;
  logic [31:0] cap_acc  = '0;
  logic [31:0] done_cap = '0;
  int          prev_n   = 0;

  task automatic send_slot(input logic lr, input logic [23:0] w, input int n);
    logic d, o;
    for (int i = 0; i < n; i++) begin
      if (i == 0) d = pend_bit;
      else        d = (i - 1 < 24) ? w[23 - (i - 1)] : 1'b0;
      sclk_cycle(lr, d, o);
      if (i == 0) begin
        if (prev_n > 0) cap_acc[31 - (prev_n - 1)] = o;
        done_cap = cap_acc;
        cap_acc  = '0;
      end else begin
        cap_acc[31 - (i - 1)] = o;
      end
    end
    pend_bit = (n - 1 < 24) ? w[23 - (n - 1)] : 1'b0;
    prev_n   = n;
  endtask

  int tb0, tb1, r0, r1, c0;

  initial begin
    // Reset state
    repeat (5) @(posedge clk);
    #1;
    chk("rst_sdout", {31'd0, i2s_sdout}, 32'd0);
    chk("rst_rx_data", {8'd0, rx_data}, 32'd0);
    chk("rst_rx_vld", {30'd0, rx_vld}, 32'd0);
    chk("rst_tx_ack", {30'd0, tx_ack}, 32'd0);
    chk("rst_frame_err", {31'd0, frame_err}, 32'd0);
    chk("rst_active", {31'd0, active}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Lead-in with lrclk low: still seeking
    send_slot(1'b0, 24'h0, 4);
    chk("seek_inactive", {31'd0, active}, 32'd0);

    // First change opens a ch1 slot. The lead-in must not be reported.
    send_slot(1'b1, 24'h123456, 32);
    chk("lock_active", {31'd0, active}, 32'd1);
    chk("lock_no_err", {31'd0, frame_err}, 32'd0);
    chk("lock_rxc0", rxc0, 32'd0);
    chk("lock_rxc1", rxc1, 32'd1);
    chk("lock_data1", {8'd0, last1}, 32'h123456);

    // ch0 slot, then ch1 slot
    tb0 = txa0;
    send_slot(1'b0, 24'hA5C3F0, 32);
    chk("ch0_rxc", rxc0, 32'd1);
    chk("ch0_data", {8'd0, last0}, 32'hA5C3F0);
    chk("ch0_ack", txa0 - tb0, 32'd1);
    chk("tx_ch1_word", done_cap, 32'h7FFFFE00);
    tb1 = txa1;
    send_slot(1'b1, 24'h123456, 32);
    chk("ch1_rxc", rxc1, 32'd2);
    chk("ch1_data", {8'd0, last1}, 32'h123456);
    chk("ch1_ack", txa1 - tb1, 32'd1);
    chk("tx_ch0_word", done_cap, 32'h80000100);

    // Short 20-bit ch0 slot, then a normal ch1 slot
    r0 = rxc0;
    send_slot(1'b0, 24'h5A5A5A, 20);
    chk("tx_ch1_word2", done_cap, 32'h7FFFFE00);
    send_slot(1'b1, 24'h0F0F0F, 32);
    chk("short_err", {31'd0, frame_err}, 32'd1);
    chk("short_no_rx", rxc0 - r0, 32'd0);
    chk("after_short_rx1", {8'd0, last1}, 32'h0F0F0F);
    chk("still_active", {31'd0, active}, 32'd1);

    // Clear the sticky flag while SCLK idles
    err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
    @(posedge clk); #1;
    chk("err_cleared", {31'd0, frame_err}, 32'd0);
    send_slot(1'b0, 24'hC0FFEE, 32);
    chk("after_clr_rx0", {8'd0, last0}, 32'hC0FFEE);
    chk("after_clr_rxc0", rxc0 - r0, 32'd1);

    // Exact 24-bit slots: each LSB lands on the next R0
    c0 = coin;
    send_slot(1'b1, 24'h3C3C3C, 24);
    send_slot(1'b0, 24'h112233, 24);
    chk("s24_rx1", {8'd0, last1}, 32'h3C3C3C);
    send_slot(1'b1, 24'hABCDEF, 24);
    chk("s24_rx0", {8'd0, last0}, 32'h112233);
    chk("s24_tx0", done_cap, 32'h80000100);
    send_slot(1'b0, 24'h000000, 32);
    chk("s24_rx1b", {8'd0, last1}, 32'hABCDEF);
    chk("s24_tx1", done_cap, 32'h7FFFFE00);
    chk("s24_coincide", coin - c0, 32'd3);
    chk("s24_no_err", {31'd0, frame_err}, 32'd0);

    // Reset in the middle of a ch1 slot
    send_slot(1'b1, 24'hFFFFFF, 6);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_sdout", {31'd0, i2s_sdout}, 32'd0);
    chk("mid_rst_rx_data", {8'd0, rx_data}, 32'd0);
    chk("mid_rst_rx_vld", {30'd0, rx_vld}, 32'd0);
    chk("mid_rst_tx_ack", {30'd0, tx_ack}, 32'd0);
    chk("mid_rst_active", {31'd0, active}, 32'd0);
    repeat (4) @(posedge clk); #1;
    rst = 1'b0;
`ifdef I2S_TGT_LOOPBACK_EN
    loopback = 1'b1;
`endif
    r0 = rxc0; r1 = rxc1;
    send_slot(1'b1, 24'hFFFFFF, 8);
    chk("post_rst_seek", {31'd0, active}, 32'd0);
    chk("post_rst_no_rx", (rxc0 - r0) + (rxc1 - r1), 32'd0);
    send_slot(1'b0, 24'h654321, 32);
    chk("relock_active", {31'd0, active}, 32'd1);
    chk("relock_rx0", {8'd0, last0}, 32'h654321);
    send_slot(1'b1, 24'h000000, 32);
    send_slot(1'b0, 24'h111111, 32);
    send_slot(1'b1, 24'h000000, 32);
`ifdef I2S_TGT_LOOPBACK_EN
    chk("loopback_echo", done_cap, 32'h65432100);
`else
    chk("relock_tx0", done_cap, 32'h80000100);
`endif

    // Pulse shape across the whole run
    chk("rx_onehot", both_rx, 32'd0);
    chk("rx_one_clk", long_rx, 32'd0);
    chk("tx_one_clk", long_tx, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
